// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI mode-0 responder: default word width,
// synchroniser depth and FSM state encoding.
package spi_slave_pkg;

   localparam int DATA_LEN_DEF    = 8;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchroniser for one asynchronous input bit.
// RST_VAL sets the idle level the chain holds during reset.
module spi_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] r_sync;

   // Shift the raw input through the flop chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder. SCLK/CS_N/MOSI are oversampled in the clk domain,
// MOSI is deserialised into DATA_LEN-bit words and a one-entry holding
// register feeds words onto MISO. Back-to-back words are supported inside
// one CS_N window: the next TX word is loaded on the falling SCLK edge that
// follows the final rising edge of the current word.
// Define SPI_MSB_FIRST_EN for MSB-first bit order (LSB-first otherwise).
module spi_slave
   import spi_slave_pkg::*;
#(
   parameter int DATA_LEN    = DATA_LEN_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sclk,
   input  logic                cs_n,
   input  logic                mosi,
   output logic                miso,
   output logic                miso_oe,
   input  logic [DATA_LEN-1:0] tx_data,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic [DATA_LEN-1:0] rx_data,
   output logic                rx_valid,
   output logic                tx_underrun,
   output logic                busy
);

   localparam int               CNT_W    = $clog2(DATA_LEN);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_LEN - 1);

   logic                w_sclk_s, w_cs_n_s, w_mosi_s;
   logic                r_sclk_d, r_cs_n_d;
   logic                w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
   state_t              r_state, w_state_nxt;
   logic                w_load, w_tx_shift, w_rx_shift, w_word_done;
   logic [DATA_LEN-1:0] r_hold, r_tx, r_rx, r_rx_data;
   logic                r_hold_full, r_underrun, r_rx_valid, r_reload;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_LEN-1:0] w_rx_next, w_tx_shifted;
   logic                w_tx_bit;

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .i_d(sclk), .o_q(w_sclk_s));
   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
      .clk(clk), .rst(rst), .i_d(cs_n), .o_q(w_cs_n_s));
   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .i_d(mosi), .o_q(w_mosi_s));

`ifdef SPI_MSB_FIRST_EN
   assign w_rx_next    = {r_rx[DATA_LEN-2:0], w_mosi_s};
   assign w_tx_shifted = {r_tx[DATA_LEN-2:0], 1'b0};
   assign w_tx_bit     = r_tx[DATA_LEN-1];
`else
   assign w_rx_next    = {w_mosi_s, r_rx[DATA_LEN-1:1]};
   assign w_tx_shifted = {1'b0, r_tx[DATA_LEN-1:1]};
   assign w_tx_bit     = r_tx[0];
`endif

   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
   assign w_cs_fall   = ~w_cs_n_s & r_cs_n_d;
   assign w_cs_rise   = w_cs_n_s & ~r_cs_n_d;
   assign w_word_done = w_rx_shift && (r_cnt == LAST_BIT);

   assign miso        = (r_state == ST_SHIFT) ? w_tx_bit : 1'b0;
   assign miso_oe     = (r_state == ST_SHIFT);
   assign busy        = (r_state == ST_SHIFT);
   assign tx_ready    = ~r_hold_full;
   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign tx_underrun = r_underrun;

   // Delayed copies of the synchronised inputs for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sclk_d <= 1'b0;
         r_cs_n_d <= 1'b1;
      end else begin
         r_sclk_d <= w_sclk_s;
         r_cs_n_d <= w_cs_n_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state plus the per-cycle TX load/shift and RX shift strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_tx_shift  = 1'b0;
      w_rx_shift  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cs_fall) begin
               w_state_nxt = ST_SHIFT;
               w_load      = 1'b1;
            end
         end
         ST_SHIFT: begin
            w_rx_shift = w_sclk_rise;
            if (w_cs_rise) begin
               w_state_nxt = ST_IDLE;
            end else if (w_sclk_fall) begin
               if (r_reload) begin
                  w_load = 1'b1;
               end else begin
                  w_tx_shift = 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Holding register: emptied by a word load, filled by the host handshake.
   // A handshake only happens while empty, so a same-cycle load sees the old
   // (empty) contents and the new word lands in the register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold_full <= 1'b0;
         r_hold      <= '0;
      end else begin
         if (w_load) begin
            r_hold_full <= 1'b0;
         end
         if (tx_valid && !r_hold_full) begin
            r_hold_full <= 1'b1;
            r_hold      <= tx_data;
         end
      end
   end

   // TX shift register: load a new word (zeros on underrun) or shift out a bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx       <= '0;
         r_underrun <= 1'b0;
      end else begin
         r_underrun <= 1'b0;
         if (w_load) begin
            r_tx       <= r_hold_full ? r_hold : '0;
            r_underrun <= ~r_hold_full;
         end else if (w_tx_shift) begin
            r_tx <= w_tx_shifted;
         end
      end
   end

   // RX assembly, bit counter, word delivery and the reload request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx       <= '0;
         r_cnt      <= '0;
         r_reload   <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         if (r_state == ST_IDLE) begin
            if (w_cs_fall) begin
               r_cnt    <= '0;
               r_rx     <= '0;
               r_reload <= 1'b0;
            end
         end else begin
            if (w_rx_shift) begin
               r_rx <= w_rx_next;
               if (w_word_done) begin
                  r_cnt      <= '0;
                  r_rx_data  <= w_rx_next;
                  r_rx_valid <= 1'b1;
                  r_reload   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            if (w_load) begin
               r_reload <= 1'b0;
            end
            // Deselect drops any partial word but keeps a word completed
            // on this same cycle.
            if (w_cs_rise) begin
               r_cnt    <= '0;
               r_reload <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave: directed and randomised SPI windows driven by a
// bench-side master, with a queue-based model of the holding register and
// word sequence, and a separate monitor that scores DUT outputs.
module tb_spi_slave;

   localparam int PH = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk = 1'b0;
   logic       cs_n = 1'b1;
   logic       mosi = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
   logic [7:0] rx_data;

   spi_slave #(.DATA_LEN(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_underrun(tx_underrun), .busy(busy));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int und_exp = 0;
   int und_seen = 0;
   logic [7:0] hold_q[$];
   logic [7:0] tx_exp_q[$];
   logic [7:0] cap_q[$];
   logic [7:0] rx_exp_q[$];
   logic [7:0] m_tx[4];
   logic [7:0] m_rx[4];
   bit         m_load[4];

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Position of the b-th transmitted bit inside a word.
   function automatic int bidx(int b);
`ifdef SPI_MSB_FIRST_EN
      return 7 - b;
`else
      return b;
`endif
   endfunction

   // A new word begins: take the host word if one is held, else zeros + underrun.
   function automatic void model_start(bit keep);
      logic [7:0] v;
      if (hold_q.size() > 0) begin
         v = hold_q.pop_front();
      end else begin
         v = 8'h00;
         und_exp++;
      end
      if (keep) tx_exp_q.push_back(v);
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [7:0] d);
      int n;
      n = 0;
      tx_data  = d;
      tx_valid = 1'b1;
      while (!tx_ready && n < 20) begin
         wait_clk(1);
         n++;
      end
      if (!tx_ready) begin
         chk("tx_ready_timeout", tx_ready, 1);
         tx_valid = 1'b0;
      end else begin
         wait_clk(1);
         tx_valid = 1'b0;
         hold_q.push_back(d);
         chk("tx_ready_after_write", tx_ready, 0);
      end
   endtask

   task automatic clock_bit(input logic mb, output logic mi);
      mosi = mb;
      wait_clk(PH);
      mi   = miso;
      sclk = 1'b1;
      wait_clk(PH);
      sclk = 1'b0;
   endtask

   task automatic end_checks(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_miso_oe"}, miso_oe, 0);
      chk({tag, "_miso"}, miso, 0);
      chk({tag, "_tx_ready"}, tx_ready, (hold_q.size() == 0));
      chk({tag, "_underruns"}, und_seen, und_exp);
      chk({tag, "_rx_pending"}, rx_exp_q.size(), 0);
      chk({tag, "_miso_pending"}, tx_exp_q.size(), 0);
   endtask

   task automatic run_window(input int nw, input int ab, input string tag);
      logic [7:0] cap;
      logic       mi;
      if (m_load[0] && hold_q.size() == 0) host_write(m_tx[0]);
      cs_n = 1'b0;
      model_start(ab == 0);
      wait_clk(PH);
      for (int w = 0; w < nw; w++) begin
         cap = 8'h00;
         for (int b = 0; b < 8; b++) begin
            if (ab != 0 && b == ab) break;
            if (b == 3 && ab == 0 && w + 1 < nw && m_load[w+1]) host_write(m_tx[w+1]);
            if (b == 7) rx_exp_q.push_back(m_rx[w]);
            clock_bit(m_rx[w][bidx(b)], mi);
            cap[bidx(b)] = mi;
         end
         if (ab != 0) break;
         cap_q.push_back(cap);
         model_start(w + 1 < nw);
      end
      wait_clk(PH);
      cs_n = 1'b1;
      wait_clk(3 * PH);
      end_checks(tag);
   endtask

   // Monitor: scores every rx_valid pulse and every captured MISO word.
   initial begin
      logic [7:0] c;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (rx_valid) begin
               if (rx_exp_q.size() == 0) chk("rx_valid_unexpected", rx_exp_q.size(), 1);
               else chk("rx_data", rx_data, rx_exp_q.pop_front());
            end
            if (tx_underrun) und_seen++;
            while (cap_q.size() > 0) begin
               c = cap_q.pop_front();
               if (tx_exp_q.size() == 0) chk("miso_word_unexpected", tx_exp_q.size(), 1);
               else chk("miso_word", c, tx_exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic mi;
      wait_clk(3);
      chk("rst_miso", miso, 0);
      chk("rst_miso_oe", miso_oe, 0);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_tx_underrun", tx_underrun, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      wait_clk(5);

      // Single word with host data loaded.
      m_tx[0] = 8'hA5; m_rx[0] = 8'h3C; m_load[0] = 1'b1;
      run_window(1, 0, "basic");

      // No host data: MISO must be all zeros with an underrun.
      m_rx[0] = 8'hFF; m_load[0] = 1'b0;
      run_window(1, 0, "underrun");

      // Two words in one window, second loaded during the first.
      m_tx[0] = 8'h11; m_tx[1] = 8'h22; m_rx[0] = 8'h01; m_rx[1] = 8'h02;
      m_load[0] = 1'b1; m_load[1] = 1'b1;
      run_window(2, 0, "b2b");

      // Abort after 5 bits, then a full word.
      m_tx[0] = 8'h99; m_rx[0] = 8'hE7; m_load[0] = 1'b1;
      run_window(1, 5, "abort");
      m_tx[0] = 8'h6B; m_rx[0] = 8'h5A; m_load[0] = 1'b1;
      run_window(1, 0, "after_abort");

      // Reset during bit 3 of a word.
      host_write(8'h77);
      cs_n = 1'b0;
      model_start(1'b0);
      wait_clk(PH);
      for (int b = 0; b < 3; b++) clock_bit(1'b1, mi);
      mosi = 1'b1;
      wait_clk(2);
      #2 rst = 1'b1;
      hold_q.delete();
      wait_clk(1);
      chk("midrst_miso", miso, 0);
      chk("midrst_miso_oe", miso_oe, 0);
      chk("midrst_tx_ready", tx_ready, 1);
      chk("midrst_rx_data", rx_data, 0);
      chk("midrst_rx_valid", rx_valid, 0);
      chk("midrst_tx_underrun", tx_underrun, 0);
      chk("midrst_busy", busy, 0);
      cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
      wait_clk(4);
      rst = 1'b0;
      wait_clk(3 * PH);
      end_checks("after_rst");

      // Bit-order pattern: first and last MISO bits both 1.
      m_tx[0] = 8'h81; m_rx[0] = 8'hC3; m_load[0] = 1'b1;
      run_window(1, 0, "order");

      // Randomised windows.
      for (int it = 0; it < 20; it++) begin
         int nw, ab;
         nw = $urandom_range(1, 3);
         for (int k = 0; k < 4; k++) begin
            m_tx[k]   = 8'($urandom);
            m_rx[k]   = 8'($urandom);
            m_load[k] = 1'($urandom_range(0, 1));
         end
         ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
         run_window(nw, ab, "rand");
      end

      wait_clk(10);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
